// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: drives the external PC register, issues fetches
// to instruction memory and buffers one delivered instruction for downstream.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_next,
    output logic        pc_write_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        trap_pend_q, trap_pend_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;

    logic        hold, req, ack_ok, fill;
    logic        eff_trap, eff_redir;
    logic [31:0] eff_tgt, addr;

    always_comb begin
        hold      = vld_q & stall;
        eff_trap  = trap_pend_q | trap;
        eff_redir = redir_pend_q | redirect_valid;
        // Newest redirect wins; target is kept word-aligned from capture onward.
        eff_tgt   = (redirect_valid ? redirect_target : tgt_q) & ~32'h3;

        req  = 1'b0;
        addr = 32'h0;
        case (state_q)
            S_REQ: begin
                req  = ~hold;
                addr = pc_q;
            end
            S_WAIT: begin
                req  = 1'b1;
                addr = addr_q;
            end
            default: ;
        endcase

        // Reset overrides everything so a late ack is never seen.
        if (!rst_n) begin
            req  = 1'b0;
            addr = 32'h0;
        end

        ack_ok = req & imem_ack;
        fill   = ack_ok & ~eff_trap & ~eff_redir;

        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (req && !imem_ack) state_d = S_WAIT;
            S_WAIT:  if (imem_ack) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        addr_d = addr_q;
        if (state_q == S_REQ && req && !imem_ack) addr_d = pc_q;

        trap_pend_d  = ack_ok ? 1'b0 : eff_trap;
        redir_pend_d = ack_ok ? 1'b0 : eff_redir;
        tgt_d        = eff_tgt;

        pc_write_enable = ack_ok;
        pc_next         = pc_q;
        if (ack_ok) begin
            if (eff_trap)       pc_next = TRAP_VECTOR;
            else if (eff_redir) pc_next = eff_tgt;
            else                pc_next = pc_q + 32'd4;
        end
        if (!rst_n) begin
            pc_write_enable = 1'b1;
            pc_next         = RESET_VECTOR;
        end

        vld_d   = fill | (vld_q & stall & ~trap & ~redirect_valid);
        instr_d = fill ? imem_rdata : instr_q;
        ipc_d   = fill ? addr : ipc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            trap_pend_q  <= 1'b0;
            redir_pend_q <= 1'b0;
            tgt_q        <= 32'h0;
            vld_q        <= 1'b0;
            instr_q      <= 32'h0;
            ipc_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            trap_pend_q  <= trap_pend_d;
            redir_pend_q <= redir_pend_d;
            tgt_q        <= tgt_d;
            vld_q        <= vld_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = addr;
    assign instr_valid = vld_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an external PC register and a
// combinational instruction memory model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_q = 32'hDEAD_BEEF;
    logic [31:0] pc_next;
    logic        pc_write_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int vec_cnt = 0;
    int err_cnt = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_q            (pc_q),
        .pc_next         (pc_next),
        .pc_write_enable (pc_write_enable),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_write_enable) pc_q <= pc_next;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0; trap = 1'b0;

        // Reset behaviour
        step(); step();
        settle();
        check_vec("rst_we",    {31'h0, pc_write_enable}, 32'h1);
        check_vec("rst_next",  pc_next, 32'h0);
        check_vec("rst_req",   {31'h0, imem_req}, 32'h0);
        check_vec("rst_addr",  imem_addr, 32'h0);
        check_vec("rst_vld",   {31'h0, instr_valid}, 32'h0);
        check_vec("rst_instr", instr, 32'h0);
        check_vec("rst_pc",    pc_q, 32'h0);

        // First cycle after release is IDLE
        rst_n = 1'b1; imem_ack = 1'b1;
        settle();
        check_vec("idle_req", {31'h0, imem_req}, 32'h0);
        check_vec("idle_we",  {31'h0, pc_write_enable}, 32'h0);
        step();

        // Back-to-back acks at 0 and 4
        for (int k = 0; k < 2; k++) begin
            settle();
            check_vec("seq_addr", imem_addr, 32'(4 * k));
            check_vec("seq_next", pc_next, 32'(4 * k + 4));
            check_vec("seq_we",   {31'h0, pc_write_enable}, 32'h1);
            step();
            check_vec("seq_vld",   {31'h0, instr_valid}, 32'h1);
            check_vec("seq_ipc",   instr_pc, 32'(4 * k));
            check_vec("seq_instr", instr, mem(32'(4 * k)));
        end

        // Ack delayed three cycles at pc=8
        imem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) imem_ack = 1'b1;
            settle();
            check_vec("wait_req",  {31'h0, imem_req}, 32'h1);
            check_vec("wait_addr", imem_addr, 32'h8);
            check_vec("wait_we",   {31'h0, pc_write_enable}, (k == 3) ? 32'h1 : 32'h0);
            if (k == 1) check_vec("wait_vld", {31'h0, instr_valid}, 32'h0);
            if (k < 3) step();
        end
        check_vec("wait_next", pc_next, 32'hC);
        step();
        check_vec("wait_ipc", instr_pc, 32'h8);

        // Redirect during WAIT at pc=16
        settle();
        check_vec("r_next16", pc_next, 32'h10);
        step();
        imem_ack = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_target = 32'h103;
        settle();
        check_vec("r_addr", imem_addr, 32'h10);
        check_vec("r_we0",  {31'h0, pc_write_enable}, 32'h0);
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        settle();
        check_vec("r_we1",  {31'h0, pc_write_enable}, 32'h1);
        check_vec("r_next", pc_next, 32'h100);
        step();
        check_vec("r_drop", {31'h0, instr_valid}, 32'h0);
        check_vec("r_addr2", imem_addr, 32'h100);
        step();
        check_vec("r_ipc", instr_pc, 32'h100);

        // Trap and redirect together
        trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
        settle();
        check_vec("t_next", pc_next, 32'h4);
        step();
        trap = 1'b0; redirect_valid = 1'b0;
        check_vec("t_drop", {31'h0, instr_valid}, 32'h0);
        check_vec("t_pc",   pc_q, 32'h4);
        step();
        check_vec("s_ipc0", instr_pc, 32'h4);

        // Stall hold for five cycles
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check_vec("s_req", {31'h0, imem_req}, 32'h0);
            check_vec("s_vld", {31'h0, instr_valid}, 32'h1);
            check_vec("s_ipc", instr_pc, 32'h4);
            check_vec("s_we",  {31'h0, pc_write_enable}, 32'h0);
            step();
        end
        check_vec("s_pc", pc_q, 32'h8);
        stall = 1'b0;
        settle();
        check_vec("s_rel_req",  {31'h0, imem_req}, 32'h1);
        check_vec("s_rel_addr", imem_addr, 32'h8);
        check_vec("s_rel_next", pc_next, 32'hC);
        step();
        check_vec("s_rel_ipc", instr_pc, 32'h8);

        // Later redirect does not override a pending trap
        imem_ack = 1'b0;
        step();
        trap = 1'b1;
        step();
        trap = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h300;
        settle();
        check_vec("p_we0", {31'h0, pc_write_enable}, 32'h0);
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        settle();
        check_vec("p_next", pc_next, 32'h4);
        step();

        // Reset while in WAIT, late ack ignored
        imem_ack = 1'b0;
        step();
        check_vec("x_addr_w", imem_addr, 32'h4);
        rst_n = 1'b0;
        settle();
        check_vec("x_we",   {31'h0, pc_write_enable}, 32'h1);
        check_vec("x_next", pc_next, 32'h0);
        check_vec("x_req",  {31'h0, imem_req}, 32'h0);
        step();
        rst_n = 1'b1; imem_ack = 1'b1;
        settle();
        check_vec("x_pc",   pc_q, 32'h0);
        check_vec("x_req2", {31'h0, imem_req}, 32'h0);
        check_vec("x_we2",  {31'h0, pc_write_enable}, 32'h0);
        check_vec("x_vld",  {31'h0, instr_valid}, 32'h0);
        step();
        check_vec("x_addr", imem_addr, 32'h0);
        check_vec("x_nx",   pc_next, 32'h4);
        step();
        check_vec("x_ipc",  instr_pc, 32'h0);
        check_vec("x_vld2", {31'h0, instr_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
